// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780 line writer.
//   lcd_state_t  - sequencer states of lcd_line_writer
//   tx_phase_t   - per-byte phases of lcd_byte_tx
//   LCD_CMD_*    - HD44780 command bytes used by the init sequence and row addressing
//   init_cmd()   - init command for a given init step (0..3)
//   printable()  - maps bytes outside 0x20..0x7E to a space
//   char_at()    - extracts character idx (0 = leftmost, in the MSBs) from a 128-bit row
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_ADDR1,
        ST_ROW1,
        ST_ADDR2,
        ST_ROW2
    } lcd_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SETUP,
        TX_PULSE,
        TX_WAIT
    } tx_phase_t;

    localparam logic [7:0] LCD_CMD_FUNC_SET   = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] LCD_CMD_DISP_ON    = 8'h0C;  // display on, cursor off, blink off
    localparam logic [7:0] LCD_CMD_CLEAR      = 8'h01;  // clear display (slow command)
    localparam logic [7:0] LCD_CMD_ENTRY      = 8'h06;  // increment address, no shift
    localparam logic [7:0] LCD_CMD_DDRAM_ROW1 = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] LCD_CMD_DDRAM_ROW2 = 8'hC0;  // DDRAM address 0x40

    localparam int ROW_CHARS = 16;

    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        logic [7:0] cmd;
        case (step)
            2'd0:    cmd = LCD_CMD_FUNC_SET;
            2'd1:    cmd = LCD_CMD_DISP_ON;
            2'd2:    cmd = LCD_CMD_CLEAR;
            default: cmd = LCD_CMD_ENTRY;
        endcase
        return cmd;
    endfunction

    function automatic logic [7:0] printable(input logic [7:0] c);
        logic [7:0] r;
        if ((c < 8'h20) || (c > 8'h7E)) begin
            r = 8'h20;
        end else begin
            r = c;
        end
        return r;
    endfunction

    function automatic logic [7:0] char_at(input logic [127:0] line, input logic [3:0] idx);
        logic [6:0] msb;
        msb = 7'd127 - {idx, 3'b000};
        return line[msb -: 8];
    endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// lcd_byte_tx: sends one byte to the HD44780 bus and waits out its execution time.
//   clk, rst     - clock, synchronous active-high reset
//   start        - 1-cycle request, accepted only while idle
//   rs, data     - register select and byte to send, captured on start
//   wait_cycles  - post-strobe wait length in clocks, captured on start (must be >= 1)
//   done         - 1-cycle pulse once the wait has elapsed
//   lcd_en       - enable strobe
//   lcd_rs       - registered register select, held until the next byte
//   lcd_data     - registered data bus, held until the next byte
//
// Timeline per byte: one setup cycle with lcd_en low, E_PULSE_CYCLES cycles
// with lcd_en high, then wait_cycles cycles with lcd_en low, then done.
// lcd_rs/lcd_data only change on start, which is only accepted after the
// previous wait, so the bus is stable around the whole strobe.
module lcd_byte_tx
    import lcd_pkg::*;
#(
    parameter int E_PULSE_CYCLES = 12,
    parameter int WAIT_W         = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rs,
    input  logic [7:0]        data,
    input  logic [WAIT_W-1:0] wait_cycles,
    output logic              done,
    output logic              lcd_en,
    output logic              lcd_rs,
    output logic [7:0]        lcd_data
);

    localparam logic [WAIT_W-1:0] E_LAST = WAIT_W'(E_PULSE_CYCLES - 1);
    localparam logic [WAIT_W-1:0] ONE    = WAIT_W'(1);

    tx_phase_t         phase;
    logic [WAIT_W-1:0] cnt;
    logic [WAIT_W-1:0] wait_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= TX_IDLE;
            cnt      <= '0;
            wait_len <= '0;
            done     <= 1'b0;
            lcd_en   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            done <= 1'b0;
            case (phase)
                TX_IDLE: begin
                    if (start) begin
                        lcd_data <= data;
                        lcd_rs   <= rs;
                        wait_len <= wait_cycles;
                        cnt      <= '0;
                        phase    <= TX_SETUP;
                    end
                end
                TX_SETUP: begin
                    // Bus has been driven for one full cycle; raise the strobe.
                    lcd_en <= 1'b1;
                    cnt    <= '0;
                    phase  <= TX_PULSE;
                end
                TX_PULSE: begin
                    if (cnt == E_LAST) begin
                        lcd_en <= 1'b0;
                        cnt    <= '0;
                        phase  <= TX_WAIT;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                TX_WAIT: begin
                    if (cnt == (wait_len - ONE)) begin
                        done  <= 1'b1;
                        cnt   <= '0;
                        phase <= TX_IDLE;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: begin
                    phase <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_line_writer.sv
// lcd_line_writer: HD44780 8-bit init plus full 16x2 redraw on request.
//   clk, rst     - 50 MHz clock, synchronous active-high reset
//   line1_text   - top row, char i at [127-8i -: 8]
//   line2_text   - bottom row, same packing
//   update_req   - 1-cycle pulse: text changed, redraw
//   init_done    - high after the init sequence, until rst
//   busy         - high during init and while a frame is being written
//   frame_done   - 1-cycle pulse when a 34-byte frame has completed
//   lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon - DE2 character-LCD pins
//
// Sequence: PWR_WAIT -> INIT(38,0C,01,06) -> IDLE -> ADDR1(80) -> ROW1(16)
// -> ADDR2(C0) -> ROW2(16) -> IDLE. Rows are taken from shadow registers
// captured when a frame starts, so mid-frame input changes never tear the
// display. Requests arriving while busy collapse into one pending frame.
module lcd_line_writer
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYCLES    = 750_000,
    parameter int E_PULSE_CYCLES    = 12,
    parameter int CHAR_WAIT_CYCLES  = 2_500,
    parameter int CLEAR_WAIT_CYCLES = 100_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] line1_text,
    input  logic [127:0] line2_text,
    input  logic         update_req,
    output logic         init_done,
    output logic         busy,
    output logic         frame_done,
    output logic [7:0]   lcd_data,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_en,
    output logic         lcd_on,
    output logic         lcd_blon
);

    localparam int MAX_WAIT = (POWERUP_CYCLES > CLEAR_WAIT_CYCLES) ? POWERUP_CYCLES
                                                                    : CLEAR_WAIT_CYCLES;
    localparam int WAIT_W   = $clog2(MAX_WAIT + 1);

    localparam logic [WAIT_W-1:0] PWR_LAST   = WAIT_W'(POWERUP_CYCLES - 1);
    localparam logic [WAIT_W-1:0] CHAR_WAIT  = WAIT_W'(CHAR_WAIT_CYCLES);
    localparam logic [WAIT_W-1:0] CLEAR_WAIT = WAIT_W'(CLEAR_WAIT_CYCLES);
    localparam logic [WAIT_W-1:0] ONE        = WAIT_W'(1);
    localparam logic [4:0]        LAST_CHAR  = 5'(ROW_CHARS - 1);

    lcd_state_t        state;
    logic [WAIT_W-1:0] pwr_cnt;
    logic [1:0]        init_idx;
    logic [4:0]        char_idx;
    logic [127:0]      shadow1;
    logic [127:0]      shadow2;
    logic              pending;
    logic              tx_active;   // byte issued to lcd_byte_tx, waiting for done

    logic              tx_start;
    logic              tx_rs;
    logic [7:0]        tx_data;
    logic [WAIT_W-1:0] tx_wait;
    logic              tx_done;

    // Write-only panel, permanently powered with backlight on.
    assign lcd_rw   = 1'b0;
    assign lcd_on   = 1'b1;
    assign lcd_blon = 1'b1;

    // Byte selection for the current sequencer state.
    always_comb begin
        tx_rs    = 1'b0;
        tx_data  = 8'h00;
        tx_wait  = CHAR_WAIT;
        tx_start = 1'b0;
        case (state)
            ST_INIT: begin
                tx_data = init_cmd(init_idx);
                if (tx_data == LCD_CMD_CLEAR) begin
                    tx_wait = CLEAR_WAIT;
                end
            end
            ST_ADDR1: tx_data = LCD_CMD_DDRAM_ROW1;
            ST_ROW1: begin
                tx_rs   = 1'b1;
                tx_data = printable(char_at(shadow1, char_idx[3:0]));
            end
            ST_ADDR2: tx_data = LCD_CMD_DDRAM_ROW2;
            ST_ROW2: begin
                tx_rs   = 1'b1;
                tx_data = printable(char_at(shadow2, char_idx[3:0]));
            end
            default: begin
                tx_data = 8'h00;
            end
        endcase
        // Every byte-sending state issues exactly one start, then waits for done.
        if ((state != ST_PWR_WAIT) && (state != ST_IDLE) && !tx_active) begin
            tx_start = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_PWR_WAIT;
            pwr_cnt    <= '0;
            init_idx   <= 2'd0;
            char_idx   <= 5'd0;
            shadow1    <= '0;
            shadow2    <= '0;
            pending    <= 1'b1;     // first frame after init is always drawn
            tx_active  <= 1'b0;
            init_done  <= 1'b0;
            busy       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (update_req) begin
                pending <= 1'b1;
            end
            if (tx_start) begin
                tx_active <= 1'b1;
            end
            case (state)
                ST_PWR_WAIT: begin
                    if (pwr_cnt == PWR_LAST) begin
                        pwr_cnt  <= '0;
                        init_idx <= 2'd0;
                        state    <= ST_INIT;
                    end else begin
                        pwr_cnt <= pwr_cnt + ONE;
                    end
                end
                ST_INIT: begin
                    if (tx_done) begin
                        tx_active <= 1'b0;
                        if (init_idx == 2'd3) begin
                            init_done <= 1'b1;
                            busy      <= pending | update_req;
                            state     <= ST_IDLE;
                        end else begin
                            init_idx <= init_idx + 2'd1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (pending) begin
                        // The snapshot taken here already contains whatever a
                        // same-cycle update_req announced, so pending clears.
                        shadow1  <= line1_text;
                        shadow2  <= line2_text;
                        pending  <= 1'b0;
                        char_idx <= 5'd0;
                        busy     <= 1'b1;
                        state    <= ST_ADDR1;
                    end else begin
                        busy <= update_req;
                    end
                end
                ST_ADDR1: begin
                    if (tx_done) begin
                        tx_active <= 1'b0;
                        char_idx  <= 5'd0;
                        state     <= ST_ROW1;
                    end
                end
                ST_ROW1: begin
                    if (tx_done) begin
                        tx_active <= 1'b0;
                        if (char_idx == LAST_CHAR) begin
                            char_idx <= 5'd0;
                            state    <= ST_ADDR2;
                        end else begin
                            char_idx <= char_idx + 5'd1;
                        end
                    end
                end
                ST_ADDR2: begin
                    if (tx_done) begin
                        tx_active <= 1'b0;
                        char_idx  <= 5'd0;
                        state     <= ST_ROW2;
                    end
                end
                ST_ROW2: begin
                    if (tx_done) begin
                        tx_active <= 1'b0;
                        if (char_idx == LAST_CHAR) begin
                            char_idx   <= 5'd0;
                            frame_done <= 1'b1;
                            busy       <= pending | update_req;
                            state      <= ST_IDLE;
                        end else begin
                            char_idx <= char_idx + 5'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_PWR_WAIT;
                end
            endcase
        end
    end

    lcd_byte_tx #(
        .E_PULSE_CYCLES (E_PULSE_CYCLES),
        .WAIT_W         (WAIT_W)
    ) u_byte_tx (
        .clk         (clk),
        .rst         (rst),
        .start       (tx_start),
        .rs          (tx_rs),
        .data        (tx_data),
        .wait_cycles (tx_wait),
        .done        (tx_done),
        .lcd_en      (lcd_en),
        .lcd_rs      (lcd_rs),
        .lcd_data    (lcd_data)
    );

endmodule
